// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the streaming CRC engine.
//   crc_preset_t   : bundle of width/poly/init/xorout/residue for a CRC flavour
//   CRC16_ARC      : reflected 0xA001, init 0, no output XOR
//   CRC16_MODBUS   : as ARC but init 0xFFFF
//   CRC32          : reflected 0xEDB88320, init/xorout all-ones, residue 0xDEBB20E3
//   crc_byte()     : one reflected byte step (8 right-shift/XOR iterations)
// ---------------------------------------------------------------------------
package crc_pkg;

  typedef struct packed {
    logic [5:0]  width;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xorout;
    logic [31:0] residue;
  } crc_preset_t;

  localparam crc_preset_t CRC16_ARC = '{width: 6'd16, poly: 32'h0000_A001,
                                        init: 32'h0000_0000, xorout: 32'h0000_0000,
                                        residue: 32'h0000_0000};

  localparam crc_preset_t CRC16_MODBUS = '{width: 6'd16, poly: 32'h0000_A001,
                                           init: 32'h0000_FFFF, xorout: 32'h0000_0000,
                                           residue: 32'h0000_0000};

  localparam crc_preset_t CRC32 = '{width: 6'd32, poly: 32'hEDB8_8320,
                                    init: 32'hFFFF_FFFF, xorout: 32'hFFFF_FFFF,
                                    residue: 32'hDEBB_20E3};

  // The register is kept LSB-aligned in a 32-bit container; the mask keeps any
  // bits above the CRC width clear so narrower CRCs never pick up stray ones.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data,
                                           input logic [31:0] poly,
                                           input int unsigned width);
    logic [31:0] c;
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    c    = crc ^ {24'd0, data};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c & mask;
  endfunction

endpackage

// File: rtl/crc_stream_if.sv
// ---------------------------------------------------------------------------
// crc_stream_if
// Beat input and result output channels of the CRC engine.
//   inValid/inReady/inData/inLast/inKeep : framed byte stream, valid/ready
//   outValid/outReady/outCrc/outLen/outOk : one-entry result channel
// Modports: master = stream producer / result consumer, slave = CRC engine.
// ---------------------------------------------------------------------------
interface crc_stream_if #(
  parameter int CRC_W  = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
);

  logic                  inValid;
  logic                  inReady;
  logic [DATA_W-1:0]     inData;
  logic                  inLast;
  logic [DATA_W/8-1:0]   inKeep;

  logic                  outValid;
  logic                  outReady;
  logic [CRC_W-1:0]      outCrc;
  logic [LEN_W-1:0]      outLen;
  logic                  outOk;

  modport master (
    output inValid, inData, inLast, inKeep, outReady,
    input  inReady, outValid, outCrc, outLen, outOk
  );

  modport slave (
    input  inValid, inData, inLast, inKeep, outReady,
    output inReady, outValid, outCrc, outLen, outOk
  );

endinterface

// File: rtl/crc_fold.sv
// ---------------------------------------------------------------------------
// crc_fold
// Combinational fold of one beat into the CRC register.
//   i_crc   : register value before the beat
//   i_data  : beat data, byte 0 in bits [7:0] is folded first
//   i_mask  : per-byte enable; disabled bytes are skipped entirely
//   o_crc   : register value after all enabled bytes
//   o_count : number of bytes folded
// ---------------------------------------------------------------------------
module crc_fold
  import crc_pkg::*;
#(
  parameter  int               CRC_W  = 16,
  parameter  logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_ARC.poly),
  parameter  int               DATA_W = 8,
  localparam int               BYTES  = DATA_W / 8,
  localparam int               CNT_W  = $clog2(BYTES + 1)
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  input  logic [BYTES-1:0]  i_mask,
  output logic [CRC_W-1:0]  o_crc,
  output logic [CNT_W-1:0]  o_count
);

  // Byte steps are chained in ascending byte order so a whole beat folds in
  // one cycle; skipped bytes simply pass the running value through.
  always_comb begin
    logic [31:0] c;
    c       = 32'(i_crc);
    o_count = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i_mask[i]) begin
        c       = crc_byte(c, i_data[8*i +: 8], 32'(POLY), CRC_W);
        o_count = o_count + CNT_W'(1);
      end
    end
    o_crc = CRC_W'(c);
  end

endmodule

// File: rtl/crc_stream.sv
// ---------------------------------------------------------------------------
// crc_stream
// Streaming reflected CRC engine with a one-entry result register.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous abort of the frame in progress and any pending result
//   bus   : crc_stream_if.slave (beat input channel and result channel)
// A frame's result appears the cycle after its last beat is accepted and is
// held until consumed; the next frame may start on the consuming edge.
// ---------------------------------------------------------------------------
module crc_stream
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_ARC.poly),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(CRC16_ARC.init),
  parameter logic [CRC_W-1:0] XOROUT  = CRC_W'(CRC16_ARC.xorout),
  parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(CRC16_ARC.residue),
  parameter int               DATA_W  = 8,
  parameter int               LEN_W   = 16
) (
  input logic          clk,
  input logic          rst_n,
  input logic          clear,
  crc_stream_if.slave  bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(BYTES + 1);

  logic [CRC_W-1:0] r_crcReg;
  logic [LEN_W-1:0] r_lenCnt;
  logic             r_outValid;
  logic [CRC_W-1:0] r_outCrc;
  logic [LEN_W-1:0] r_outLen;
  logic             r_outOk;

  logic             w_accept;
  logic [BYTES-1:0] w_mask;
  logic [CRC_W-1:0] w_nextCrc;
  logic [CNT_W-1:0] w_count;
  logic [LEN_W:0]   w_lenSum;
  logic [LEN_W-1:0] w_nextLen;

  // Ready only looks at the result slot and clear, never at inValid, so the
  // upstream side can't form a combinational loop through this block.
  assign bus.inReady = !(r_outValid && !bus.outReady) && !clear;
  assign w_accept    = bus.inValid && bus.inReady;

  // Keep bits only matter on the final beat; earlier beats are always full.
  assign w_mask = bus.inLast ? bus.inKeep : {BYTES{1'b1}};

  crc_fold #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_fold (
    .i_crc   (r_crcReg),
    .i_data  (bus.inData),
    .i_mask  (w_mask),
    .o_crc   (w_nextCrc),
    .o_count (w_count)
  );

  // One extra carry bit detects overflow so the length sticks at all-ones.
  assign w_lenSum  = {1'b0, r_lenCnt} + (LEN_W+1)'(w_count);
  assign w_nextLen = w_lenSum[LEN_W] ? {LEN_W{1'b1}} : w_lenSum[LEN_W-1:0];

  // Running accumulator: advances on every accepted beat and restarts from
  // INIT after the last beat so back-to-back frames need no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crcReg <= INIT;
      r_lenCnt <= '0;
    end else if (clear) begin
      r_crcReg <= INIT;
      r_lenCnt <= '0;
    end else if (w_accept) begin
      if (bus.inLast) begin
        r_crcReg <= INIT;
        r_lenCnt <= '0;
      end else begin
        r_crcReg <= w_nextCrc;
        r_lenCnt <= w_nextLen;
      end
    end
  end

  // Result slot: a newly completed frame wins over consumption of the old one
  // on the same edge; otherwise the slot empties when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outCrc   <= '0;
      r_outLen   <= '0;
      r_outOk    <= 1'b0;
    end else if (clear) begin
      r_outValid <= 1'b0;
    end else if (w_accept && bus.inLast) begin
      r_outValid <= 1'b1;
      r_outCrc   <= w_nextCrc ^ XOROUT;
      r_outLen   <= w_nextLen;
      r_outOk    <= (w_nextCrc == RESIDUE);
    end else if (r_outValid && bus.outReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.outValid = r_outValid;
  assign bus.outCrc   = r_outCrc;
  assign bus.outLen   = r_outLen;
  assign bus.outOk    = r_outOk;

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Streaming, parametrised CRC engine. Successor to the single-byte combinational CRC-16 step.
- Accepts a framed byte stream, DATA_W/8 bytes per beat, with valid/ready handshake.
- Accumulates a reflected (right-shift) CRC of configurable width and polynomial.
- On the last beat, emits the final CRC, the frame byte count and a residue-check flag through a one-entry output register.
- Sits between packet receive/transmit datapaths and the framing logic that appends or checks CRCs.

Parameters:
- CRC_W, 16: CRC register width in bits; legal range 8..32.
- POLY, 16'hA001: polynomial in reflected (right-shift) form, CRC_W bits.
- INIT, 16'h0000: register value at frame start.
- XOROUT, 16'h0000: value XORed into the register to form outCrc.
- RESIDUE, 16'h0000: register value (before XOROUT) that indicates a good frame when the frame includes its own appended CRC, LSB first.
- DATA_W, 8: input beat width; multiple of 8; legal values 8, 16, 32, 64.
- LEN_W, 16: byte counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discards the frame in progress and the pending output.
- inValid  in  1  beat valid.
- inReady  out  1  beat accepted when inValid && inReady.
- inData  in  DATA_W  beat data; byte 0 = bits [7:0], processed first.
- inLast  in  1  final beat of frame.
- inKeep  in  DATA_W/8  byte enables; examined only when inLast=1.
- outValid  out  1  result valid.
- outReady  in  1  result consumed when outValid && outReady.
- outCrc  out  CRC_W  final register XOR XOROUT.
- outLen  out  LEN_W  bytes in frame; saturates at all-ones.
- outOk  out  1  final register (pre-XOROUT) == RESIDUE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - crcReg=INIT, lenCnt=0.
  - outValid=0, outCrc=0, outLen=0, outOk=0.
  - inReady=1 after reset deasserts.
- Ready rule: inReady = !(outValid && !outReady) && !clear. Fully combinational from outValid, outReady and clear; no dependence on inValid.
- Per accepted beat:
  - Bytes i=0..BYTES-1 are folded in ascending order through the byte step.
  - Byte i is folded iff !inLast || inKeep[i].
  - All BYTES steps are unrolled into one combinational chain; one beat per cycle at full throughput.
  - lenCnt increases by the number of folded bytes, saturating.
- Non-last beat: crcReg and lenCnt update on the accepting edge.
- Last beat, on the accepting edge:
  - Compute next = fold(crcReg, beat).
  - Load outCrc=next^XOROUT, outOk=(next==RESIDUE), outLen=lenCnt+folded bytes (saturating).
  - Set outValid=1.
  - Reinitialise crcReg=INIT, lenCnt=0.
- Latency: result visible the cycle after the last beat is accepted.
- Next frame: its first beat may be accepted in the same cycle the previous result is consumed. No bubble is required.
- inKeep on last beat:
  - inKeep=0 is an empty final beat; the frame still completes.
  - A single-beat frame with inKeep=0 gives outCrc=INIT^XOROUT, outLen=0.
  - Non-contiguous keep bits are legal; only enabled bytes are folded, in ascending order.
- Output hold: outValid stays high and outCrc/outLen/outOk stay stable until outReady. Clearing occurs on the same edge that consumes the result, unless a new result loads on that edge; the new result then takes priority.
- clear:
  - Next edge: crcReg=INIT, lenCnt=0, outValid=0.
  - Any beat presented with clear high is not accepted, because inReady is low.
- Reset mid-frame: partial state is lost; the bench must restart the frame.
- Width rule: outLen saturation holds at 2^LEN_W-1 and never wraps.

Decomposition:
- Shared package crc_pkg holds:
  - a byte-step function crc_byte(crc, byte, poly, width), implementing the reflected 8-iteration shift/XOR;
  - named constants for the standard presets: CRC16_ARC, CRC16_MODBUS (INIT 16'hFFFF), CRC32 (POLY 32'hEDB88320, INIT/XOROUT 32'hFFFFFFFF, RESIDUE 32'hDEBB20E3).
- One sub-module, crc_fold: purely combinational. Takes crcReg, inData and the byte-enable mask; returns the folded CRC and the folded byte count. It is instantiated once and unrolled over BYTES.

Test Plan:
- DATA_W=8, defaults; "123456789" (0x31..0x39), inLast on 0x39 -> one cycle later outValid=1, outCrc=16'hBB3D, outLen=9.
- INIT=16'hFFFF, same stream -> outCrc=16'h4B37 (MODBUS); DATA_W=32, beats 0x34333231, 0x38373635, 0x00000039 with inKeep=4'b0001 -> outCrc=16'hBB3D, outLen=9.
- Residue check, DATA_W=8: "123456789" followed by 0x3D, 0xBB -> outOk=1, outLen=11. Flip bit 0 of byte 4 -> outOk=0.
- Backpressure: hold outReady=0 after frame A completes; present frame B -> inReady=0, frame A outputs stable. Raise outReady -> A consumed, B's first beat accepted in the same cycle, B result correct.
- Assert clear after 4 bytes, then send "123456789" -> outCrc=16'hBB3D, outLen=9. Repeat with rst_n pulsed low mid-frame -> outValid=0 immediately, then the next frame gives the same correct result.
- Edge cases:
  - single beat with inLast and inKeep=0 -> outCrc=INIT^XOROUT, outLen=0;
  - LEN_W=4 with a 20-byte frame -> outLen=15 (saturated).
